hd63701_intc: RTL and testbench
===============================

Name: hd63701_intc

Overview:
Interrupt sequencer for the HD63701 core. It synchronises and latches the external and on-chip interrupt sources and arbitrates them by fixed priority at instruction boundaries. It presents one frozen vector low byte to the microcode sequencer and holds it until the core acknowledges the vector fetch. It also generates the wake-up for the WAI and SLP halt states.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the synchronisers on nmi_n and irq1_n (minimum 1).

Ports:
CLK  input  1  core clock; all state updates on posedge
RST  input  1  asynchronous, active-high reset
nmi_n  input  1  external NMI, falling-edge sensitive, asynchronous
irq1_n  input  1  external IRQ1, level, active-low, asynchronous
src_icf  input  1  timer input-capture flag AND its enable, level, CLK-synchronous
src_ocf  input  1  timer output-compare flag AND its enable, level, synchronous
src_tof  input  1  timer overflow flag AND its enable, level, synchronous
src_sci  input  1  serial interrupt (RDRF/TDRE/ORFE gated), level, synchronous
inte  input  1  1 = CCR I bit clear (maskable interrupts allowed)
boundary  input  1  one-cycle pulse on the cycle the core fetches an opcode
ack  input  1  one-cycle pulse when the core starts the vector fetch
wai  input  1  core halted in WAI (registers already stacked)
slp  input  1  core halted in SLP
req  output  1  interrupt request to the microcode sequencer
vec  output  8  vector low byte (address = FF:vec); valid while req=1
wake  output  1  one-cycle pulse releasing WAI/SLP
pend  output  6  raw pending status {nmi,irq1,icf,ocf,tof,sci}, for debug

Behaviour:
- Reset (async, RST=1): req=0, vec=8'h00, wake=0, pend=0, NMI latch=0, synchronisers to 1 (inactive), state=IDLE. Reset in any state aborts the pending grant immediately. No ack is expected afterwards.
- Synchronisers: nmi_n and irq1_n each pass through SYNC_STAGES flops.
  - NMI edge = synced value 1 -> 0 between consecutive cycles. The edge sets nmi_lat on the next posedge.
  - An nmi_n fall at cycle 0 gives nmi_lat=1 after cycle SYNC_STAGES+1 (3 cycles with the default).
  - A low level held on nmi_n gives a single edge only.
- pend = {nmi_lat, ~irq1_s, src_icf, src_ocf, src_tof, src_sci}, registered, one cycle after its inputs.
- Eligible set: nmi_lat always. The other five sources only when inte=1.
- Priority, highest first, with vec value:
  - NMI=FC
  - IRQ1=F8
  - ICF=F6
  - OCF=F4
  - TOF=F2
  - SCI=F0
- State machine (registered, 2 states):
  - IDLE: sample when (boundary | wai) and the eligible set is non-empty. Load vec with the highest-priority eligible source, record the granted source, set req=1, go to PEND. req and vec are visible the cycle after sampling.
  - PEND: req=1 and vec frozen. Higher-priority arrivals, deassertion of a maskable source, and inte changes are all ignored; the grant stands. On ack: req=0, vec keeps its value, go to IDLE.
    - If the grant was NMI, nmi_lat clears on the same edge.
    - A new NMI edge detected on the ack cycle wins: nmi_lat stays 1.
  - ack in IDLE is ignored.
  - boundary in PEND is ignored.
  - After returning to IDLE, the earliest re-sample is the next boundary (back-to-back grants are allowed).
- Maskable sources are not latched. Clearing them is the owning peripheral's job; this block only reads levels.
- Wake:
  - wake pulses for one cycle when wai=1 and the eligible set is non-empty. The same cycle also performs the IDLE sample.
  - wake also pulses when slp=1 and any pend bit is set, regardless of inte. SLP wake does not grant a vector unless the source is eligible at the next boundary.
  - wake re-fires only after the eligible/pend condition has dropped and re-risen, or after wai/slp has been deasserted and re-asserted. There is no continuous retrigger.
- Simultaneous boundary and ack are legal only in PEND. Ack is processed, no new sample is taken that cycle.
- Expected implementation size: about 150-250 lines.

Test Plan:
- Reset release, all sources idle, boundary pulses -> req=0, vec=00, wake never asserts.
- inte=1, src_ocf=1 and src_tof=1, then boundary -> next cycle req=1, vec=F4. ack -> req=0. Next boundary with both still set -> vec=F4 again.
- inte=0, irq1_n=0, boundary -> no req. Raise inte, next boundary -> req=1, vec=F8 after the sync delay (irq1_n low at least 2 cycles).
- nmi_n falls while in PEND with vec=F6 -> vec stays F6. After ack, next boundary -> vec=FC. ack clears pend[5].
- NMI edge arriving on the same cycle as the ack of an NMI grant -> pend[5] stays 1. Next boundary -> vec=FC.
- wai=1, inte=1, src_sci asserted -> exactly one wake pulse, req=1, vec=F0.
- slp=1, inte=0, src_tof=1 -> wake pulses, req stays 0.
- Assert RST while in PEND -> req=0, vec=00 asynchronously.

Source files
------------

// File: rtl/hd63701_intc.sv
// HD63701 interrupt sequencer: synchronises and latches the interrupt sources, grants the
// highest-priority eligible source at instruction boundaries, and wakes the core from WAI/SLP.
module hd63701_intc #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       nmi_n,
  input  logic       irq1_n,
  input  logic       src_icf,
  input  logic       src_ocf,
  input  logic       src_tof,
  input  logic       src_sci,
  input  logic       inte,
  input  logic       boundary,
  input  logic       ack,
  input  logic       wai,
  input  logic       slp,
  output logic       req,
  output logic [7:0] vec,
  output logic       wake,
  output logic [5:0] pend
);

  typedef enum logic {IDLE, PEND} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] nmi_sync_q, irq_sync_q;
  logic [SYNC_STAGES:0]   nmi_shift, irq_shift;
  logic                   nmi_s, irq1_s, nmi_prev_q, nmi_edge;
  logic                   nmi_lat_q, nmi_lat_d;
  logic                   gnt_nmi_q, gnt_nmi_d;
  logic [7:0]             vec_q, vec_d;
  logic [5:0]             pend_q, raw, elig;
  logic                   wcond, wcond_q, wake_q;
  logic [7:0]             pri_vec;

  assign nmi_shift = {nmi_sync_q, nmi_n};
  assign irq_shift = {irq_sync_q, irq1_n};
  assign nmi_s     = nmi_sync_q[SYNC_STAGES-1];
  assign irq1_s    = irq_sync_q[SYNC_STAGES-1];
  assign nmi_edge  = nmi_prev_q & ~nmi_s;

  assign raw  = {nmi_lat_q, ~irq1_s, src_icf, src_ocf, src_tof, src_sci};
  assign elig = raw & {1'b1, {5{inte}}};

  // Wake is edge-triggered on this condition so a held source cannot retrigger it.
  assign wcond = (wai & (|elig)) | (slp & (|pend_q));

  always_comb begin
    pri_vec = 8'h00;
    if      (elig[5]) pri_vec = 8'hFC;
    else if (elig[4]) pri_vec = 8'hF8;
    else if (elig[3]) pri_vec = 8'hF6;
    else if (elig[2]) pri_vec = 8'hF4;
    else if (elig[1]) pri_vec = 8'hF2;
    else if (elig[0]) pri_vec = 8'hF0;
  end

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    gnt_nmi_d = gnt_nmi_q;
    nmi_lat_d = nmi_lat_q;
    case (state_q)
      IDLE: begin
        if ((boundary | wai) && (|elig)) begin
          state_d   = PEND;
          vec_d     = pri_vec;
          gnt_nmi_d = elig[5];
        end
      end
      PEND: begin
        if (ack) begin
          state_d = IDLE;
          if (gnt_nmi_q) nmi_lat_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    // A fresh edge on the acknowledge cycle must survive the clear above.
    if (nmi_edge) nmi_lat_d = 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      nmi_sync_q <= '1;
      irq_sync_q <= '1;
      nmi_prev_q <= 1'b1;
      nmi_lat_q  <= 1'b0;
      gnt_nmi_q  <= 1'b0;
      vec_q      <= '0;
      pend_q     <= '0;
      wcond_q    <= 1'b0;
      wake_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      nmi_sync_q <= nmi_shift[SYNC_STAGES-1:0];
      irq_sync_q <= irq_shift[SYNC_STAGES-1:0];
      nmi_prev_q <= nmi_s;
      nmi_lat_q  <= nmi_lat_d;
      gnt_nmi_q  <= gnt_nmi_d;
      vec_q      <= vec_d;
      pend_q     <= raw;
      wcond_q    <= wcond;
      wake_q     <= wcond & ~wcond_q;
    end
  end

  assign req  = (state_q == PEND);
  assign vec  = vec_q;
  assign wake = wake_q;
  assign pend = pend_q;

endmodule

// File: tb/tb_hd63701_intc.sv
// Self-checking bench for hd63701_intc: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural model of the interrupt rules.
module tb_hd63701_intc;
  localparam int S = 2;

  logic CLK, RST, nmi_n, irq1_n, src_icf, src_ocf, src_tof, src_sci;
  logic inte, boundary, ack, wai, slp;
  logic req, wake;
  logic [7:0] vec;
  logic [5:0] pend;

  int tests = 0;
  int fails = 0;

  hd63701_intc #(.SYNC_STAGES(S)) dut (
    .CLK(CLK), .RST(RST), .nmi_n(nmi_n), .irq1_n(irq1_n),
    .src_icf(src_icf), .src_ocf(src_ocf), .src_tof(src_tof), .src_sci(src_sci),
    .inte(inte), .boundary(boundary), .ack(ack), .wai(wai), .slp(slp),
    .req(req), .vec(vec), .wake(wake), .pend(pend)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: input history queues, a granted flag and the NMI latch.
  bit         nq[$], iq[$];
  bit         m_pend, m_gn, m_nmi, m_wake, m_cprev, m_edge, m_irq_s, m_c;
  logic [7:0] m_vec;
  logic [5:0] m_pb, m_raw, m_el;

  function automatic logic [7:0] pick_vec(input logic [5:0] el);
    logic [7:0] t [6] = '{8'hF0, 8'hF2, 8'hF4, 8'hF6, 8'hF8, 8'hFC};
    for (int i = 5; i >= 0; i--)
      if (el[i]) return t[i];
    return 8'h00;
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_pend = 0; m_gn = 0; m_nmi = 0; m_wake = 0; m_cprev = 0;
      m_vec = 8'h00; m_pb = 6'h00;
      nq.delete(); iq.delete();
      for (int i = 0; i <= S; i++) begin nq.push_back(1'b1); iq.push_back(1'b1); end
    end else begin
      m_edge  = nq[S] && !nq[S-1];
      m_irq_s = iq[S-1];
      m_raw   = {m_nmi, ~m_irq_s, src_icf, src_ocf, src_tof, src_sci};
      m_el    = m_raw & {1'b1, {5{inte}}};
      m_c     = (wai && m_el != 0) || (slp && m_pb != 0);
      m_wake  = m_c && !m_cprev;
      m_cprev = m_c;
      m_pb    = m_raw;
      if (!m_pend) begin
        if ((boundary || wai) && m_el != 0) begin
          m_pend = 1; m_vec = pick_vec(m_el); m_gn = m_el[5];
        end
      end else if (ack) begin
        m_pend = 0;
        if (m_gn) m_nmi = 0;
      end
      if (m_edge) m_nmi = 1;
      nq.push_front(nmi_n); void'(nq.pop_back());
      iq.push_front(irq1_n); void'(iq.pop_back());
    end
  end

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic pulse_boundary();
    boundary = 1; tick(); boundary = 0;
  endtask

  task automatic pulse_ack();
    ack = 1; tick(); ack = 0;
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if ({req, vec, wake, pend} !== 16'h0000) begin
      fails++; $display("FAIL reset_async got req=%b vec=%h wake=%b pend=%b need all zero", req, vec, wake, pend);
    end
    @(negedge CLK) RST = 0;
    for (int i = 0; i < 6; i++) begin
      boundary = i[0]; tick();
      tests++;
      if ({req, vec, wake} !== 10'h000) begin
        fails++; $display("FAIL reset_idle got req=%b vec=%h wake=%b need 0/00/0", req, vec, wake);
      end
    end
    boundary = 0;
  endtask

  task automatic test_ocf_tof();
    inte = 1; src_ocf = 1; src_tof = 1; tick();
    pulse_boundary();
    tests++;
    if (req !== 1'b1 || vec !== 8'hF4) begin
      fails++; $display("FAIL ocf_grant got req=%b vec=%h need 1/F4", req, vec);
    end
    for (int i = 0; i < 3; i++) pulse_boundary();
    tests++;
    if (req !== 1'b1 || vec !== 8'hF4) begin
      fails++; $display("FAIL ocf_hold got req=%b vec=%h need 1/F4", req, vec);
    end
    pulse_ack();
    tests++;
    if (req !== 1'b0 || vec !== 8'hF4) begin
      fails++; $display("FAIL ocf_ack got req=%b vec=%h need 0/F4", req, vec);
    end
    pulse_boundary();
    tests++;
    if (req !== 1'b1 || vec !== 8'hF4) begin
      fails++; $display("FAIL ocf_regrant got req=%b vec=%h need 1/F4", req, vec);
    end
    pulse_ack();
    src_ocf = 0; src_tof = 0; inte = 0; tick();
  endtask

  task automatic test_irq1_mask();
    inte = 0; irq1_n = 0;
    repeat (S + 1) tick();
    pulse_boundary();
    tests++;
    if (req !== 1'b0) begin
      fails++; $display("FAIL irq1_masked got req=%b need 0", req);
    end
    inte = 1;
    pulse_boundary();
    tests++;
    if (req !== 1'b1 || vec !== 8'hF8) begin
      fails++; $display("FAIL irq1_grant got req=%b vec=%h need 1/F8", req, vec);
    end
    pulse_ack();
    irq1_n = 1; inte = 0;
    repeat (S + 1) tick();
  endtask

  task automatic test_nmi_in_pend();
    inte = 1; src_icf = 1;
    pulse_boundary();
    nmi_n = 0;
    repeat (S + 3) tick();
    tests++;
    if (req !== 1'b1 || vec !== 8'hF6 || pend[5] !== 1'b1) begin
      fails++; $display("FAIL nmi_frozen got req=%b vec=%h pend5=%b need 1/F6/1", req, vec, pend[5]);
    end
    pulse_ack();
    src_icf = 0;
    pulse_boundary();
    tests++;
    if (req !== 1'b1 || vec !== 8'hFC) begin
      fails++; $display("FAIL nmi_after got req=%b vec=%h need 1/FC", req, vec);
    end
    pulse_ack();
    tick(); tick();
    tests++;
    if (pend[5] !== 1'b0) begin
      fails++; $display("FAIL nmi_clear got pend5=%b need 0", pend[5]);
    end
    nmi_n = 1; inte = 0;
    repeat (S + 2) tick();
  endtask

  task automatic test_nmi_ack_collision();
    nmi_n = 0;
    repeat (S + 3) tick();
    pulse_boundary();
    tests++;
    if (req !== 1'b1 || vec !== 8'hFC) begin
      fails++; $display("FAIL coll_grant got req=%b vec=%h need 1/FC", req, vec);
    end
    nmi_n = 1;
    repeat (S + 2) tick();
    nmi_n = 0;
    repeat (S) tick();
    pulse_ack();
    tick(); tick();
    tests++;
    if (pend[5] !== 1'b1 || req !== 1'b0) begin
      fails++; $display("FAIL coll_keep got pend5=%b req=%b need 1/0", pend[5], req);
    end
    pulse_boundary();
    tests++;
    if (req !== 1'b1 || vec !== 8'hFC) begin
      fails++; $display("FAIL coll_regrant got req=%b vec=%h need 1/FC", req, vec);
    end
    pulse_ack();
    nmi_n = 1;
    repeat (S + 2) tick();
  endtask

  task automatic test_wai_wake();
    int wakes = 0;
    inte = 1; wai = 1; src_sci = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (wake === 1'b1) wakes++;
    end
    tests++;
    if (wakes != 1 || req !== 1'b1 || vec !== 8'hF0) begin
      fails++; $display("FAIL wai_wake got wakes=%0d req=%b vec=%h need 1/1/F0", wakes, req, vec);
    end
    ack = 1; wai = 0; src_sci = 0; tick(); ack = 0;
    inte = 0; tick();
  endtask

  task automatic test_slp_wake();
    int wakes = 0;
    int reqs = 0;
    inte = 0; slp = 1; src_tof = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (wake === 1'b1) wakes++;
      if (req !== 1'b0) reqs++;
    end
    tests++;
    if (wakes != 1 || reqs != 0) begin
      fails++; $display("FAIL slp_wake got wakes=%0d req_cycles=%0d need 1/0", wakes, reqs);
    end
    slp = 0; src_tof = 0; tick(); tick();
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) nmi_n  = ~nmi_n;
      if ($urandom_range(0, 5) == 0) irq1_n = ~irq1_n;
      if ($urandom_range(0, 3) == 0) src_icf = ~src_icf;
      if ($urandom_range(0, 3) == 0) src_ocf = ~src_ocf;
      if ($urandom_range(0, 3) == 0) src_tof = ~src_tof;
      if ($urandom_range(0, 3) == 0) src_sci = ~src_sci;
      if ($urandom_range(0, 7) == 0) inte = ~inte;
      if ($urandom_range(0, 15) == 0) wai = ~wai;
      if ($urandom_range(0, 15) == 0) slp = ~slp;
      boundary = ($urandom_range(0, 2) == 0);
      ack      = m_pend && ($urandom_range(0, 3) == 0);
      tick();
      tests++;
      if ({req, vec, wake, pend} !== {m_pend, m_vec, m_wake, m_pb}) begin
        fails++; bad++;
        if (bad < 10)
          $display("FAIL random_c%0d got req=%b vec=%h wake=%b pend=%b need req=%b vec=%h wake=%b pend=%b",
                   i, req, vec, wake, pend, m_pend, m_vec, m_wake, m_pb);
      end
    end
    boundary = 0; ack = 0; wai = 0; slp = 0; inte = 0;
    nmi_n = 1; irq1_n = 1; src_icf = 0; src_ocf = 0; src_tof = 0; src_sci = 0;
    if (m_pend) pulse_ack();
    repeat (S + 3) tick();
    if (m_pend) pulse_ack();
  endtask

  task automatic test_reset_in_pend();
    inte = 1; src_ocf = 1;
    pulse_boundary();
    tests++;
    if (req !== 1'b1) begin
      fails++; $display("FAIL rstpend_grant got req=%b need 1", req);
    end
    #2 RST = 1;
    #1;
    tests++;
    if ({req, vec, wake, pend} !== 16'h0000) begin
      fails++; $display("FAIL rstpend_async got req=%b vec=%h wake=%b pend=%b need all zero", req, vec, wake, pend);
    end
    @(negedge CLK) RST = 0;
    src_ocf = 0; inte = 0;
    tick();
    tests++;
    if (req !== 1'b0 || vec !== 8'h00) begin
      fails++; $display("FAIL rstpend_after got req=%b vec=%h need 0/00", req, vec);
    end
  endtask

  initial begin
    RST = 1; nmi_n = 1; irq1_n = 1;
    src_icf = 0; src_ocf = 0; src_tof = 0; src_sci = 0;
    inte = 0; boundary = 0; ack = 0; wai = 0; slp = 0;
    test_reset();
    test_ocf_tof();
    test_irq1_mask();
    test_nmi_in_pend();
    test_nmi_ack_collision();
    test_wai_wake();
    test_slp_wake();
    test_random();
    test_reset_in_pend();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
